// File: rtl/slavefifo2b_pkg.sv
// Shared constants for the FX3 slave-FIFO stream-IN path.
// DATA_W      : width of one stream word, also imported by the stream-IN writer.
// DROP_CNT_W  : width of the saturating dropped-write counter.
// DEFAULT_*   : default buffer geometry for slavefifo2b_in_buffer.
package slavefifo2b_pkg;
  localparam int DATA_W         = 32;
  localparam int DROP_CNT_W     = 16;
  localparam int DEFAULT_DEPTH  = 512;
  localparam int DEFAULT_ADDR_W = 9;
  localparam int DEFAULT_AE     = 4;
endpackage

// File: rtl/slavefifo2b_fwft_ram.sv
// DEPTH x DATA_W storage for the stream-IN buffer: one synchronous write port
// and one asynchronous read port, so it maps onto distributed RAM and the head
// word is visible combinationally for first-word-fall-through reads.
// Ports:
//   clk_100 : write clock
//   we      : write enable
//   waddr   : write address
//   wdata   : write data
//   raddr   : read address
//   rdata   : read data (combinational from raddr)
module slavefifo2b_fwft_ram
  import slavefifo2b_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk_100,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_100) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/slavefifo2b_in_buffer.sv
// Upstream elastic stage for the FX3 slave-FIFO stream-IN writer.
// Accepts a free-running sample stream (or an internal incrementing test
// pattern) into a first-word-fall-through buffer and presents the head word
// to the writer, which pops one word per cycle of rd_en.
// Ports:
//   clk_100, reset_ : clock, asynchronous active-low reset
//   clear           : synchronous flush of pointers, counters and status
//   pattern_en      : 1 selects the internal counter as source, 0 selects src_*
//   src_valid/data  : sample stream, no backpressure
//   rd_en           : pop the head word
//   dout            : head word, valid whenever empty=0
//   empty, almost_empty, word_count : fill status
//   overflow, underflow, drop_count : sticky diagnostics
module slavefifo2b_in_buffer
  import slavefifo2b_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int AE_LEVEL = DEFAULT_AE
) (
  input  logic                  clk_100,
  input  logic                  reset_,
  input  logic                  clear,
  input  logic                  pattern_en,
  input  logic                  src_valid,
  input  logic [DATA_W-1:0]     src_data,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     dout,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_W:0]       word_count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AE_CNT   = (ADDR_W+1)'(AE_LEVEL);

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [DATA_W-1:0] pattern_cnt;
  logic              full;
  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic              wr_acc;
  logic              rd_acc;

  // Pointers carry one extra bit, so their difference is the fill level
  // 0..DEPTH without a separate up/down counter.
  assign word_count   = wr_ptr - rd_ptr;
  assign full         = (word_count == FULL_CNT);
  assign empty        = (word_count == '0);
  assign almost_empty = (word_count <= AE_CNT);

  assign wr_req  = pattern_en ? 1'b1 : src_valid;
  assign wr_data = pattern_en ? pattern_cnt : src_data;

  // full/empty are this cycle's values: a same-cycle pop never makes room for
  // a write, and a same-cycle write never feeds a pop.
  assign wr_acc = wr_req & ~full & ~clear;
  assign rd_acc = rd_en & ~empty & ~clear;

  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pattern_cnt <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      drop_count  <= '0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pattern_cnt <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      drop_count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;

      // Counter only advances on accepted pattern words, so the pattern stays
      // gap-free across full periods; it restarts from 0 on every enable.
      if (!pattern_en)  pattern_cnt <= '0;
      else if (wr_acc)  pattern_cnt <= pattern_cnt + 1'b1;

      if (wr_req && full) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc(drop_count);
      end

      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  slavefifo2b_fwft_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_100 (clk_100),
    .we      (wr_acc),
    .waddr   (wr_ptr[ADDR_W-1:0]),
    .wdata   (wr_data),
    .raddr   (rd_ptr[ADDR_W-1:0]),
    .rdata   (dout)
  );

endmodule

// File: tb/tb_slavefifo2b_in_buffer.sv
// Directed self-checking bench for slavefifo2b_in_buffer (DEPTH=512).
module tb_slavefifo2b_in_buffer;

  logic        clk_100 = 1'b0;
  logic        reset_;
  logic        clear;
  logic        pattern_en;
  logic        src_valid;
  logic [31:0] src_data;
  logic        rd_en;
  logic [31:0] dout;
  logic        empty;
  logic        almost_empty;
  logic [9:0]  word_count;
  logic        overflow;
  logic        underflow;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;

  slavefifo2b_in_buffer dut (
    .clk_100      (clk_100),
    .reset_       (reset_),
    .clear        (clear),
    .pattern_en   (pattern_en),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .rd_en        (rd_en),
    .dout         (dout),
    .empty        (empty),
    .almost_empty (almost_empty),
    .word_count   (word_count),
    .overflow     (overflow),
    .underflow    (underflow),
    .drop_count   (drop_count)
  );

  always #5 clk_100 = ~clk_100;

  task automatic step();
    @(posedge clk_100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wc"},    32'(word_count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_ae"},    32'(almost_empty), 32'd1);
    chk({tag, "_ovf"},   32'(overflow), 32'd0);
    chk({tag, "_unf"},   32'(underflow), 32'd0);
    chk({tag, "_drop"},  32'(drop_count), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_v;
    reset_     = 1'b0;
    clear      = 1'b0;
    pattern_en = 1'b0;
    src_valid  = 1'b0;
    src_data   = '0;
    rd_en      = 1'b0;

    #12;
    chk_reset_state("reset");
    step();
    reset_ = 1'b1;

    // Pattern fill for DEPTH+5 cycles with no reads: 512 stored, 5 dropped.
    pattern_en = 1'b1;
    repeat (517) step();
    chk("fill_wc",   32'(word_count), 32'd512);
    chk("fill_dout", dout, 32'h0);
    chk("fill_ovf",  32'(overflow), 32'd1);
    chk("fill_drop", 32'(drop_count), 32'd5);
    chk("fill_ae",   32'(almost_empty), 32'd0);

    // Start popping: the first cycle is still full so one more drop, then the
    // pattern continues gap-free through 512 and beyond.
    rd_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      chk("pat_seq", dout, 32'(i));
      step();
    end
    chk("pat_drop", 32'(drop_count), 32'd6);
    chk("pat_wc",   32'(word_count), 32'd511);

    // Stop the source and drain the remaining 511 words (600..1110).
    pattern_en = 1'b0;
    exp_v = 32'd600;
    for (int n = 0; n < 600; n++) begin
      if (empty) break;
      chk("drain_seq", dout, exp_v);
      exp_v++;
      step();
    end
    rd_en = 1'b0;
    chk("drain_end", exp_v, 32'd1111);
    chk("drain_unf", 32'(underflow), 32'd0);

    // External source, ten spaced pulses, no reads.
    for (int k = 0; k < 10; k++) begin
      src_valid = 1'b1;
      src_data  = 32'hA000_0000 + 32'(k);
      step();
      src_valid = 1'b0;
      chk("src_wc", 32'(word_count), 32'(k + 1));
      chk("src_ae", 32'(almost_empty), (k + 1 <= 4) ? 32'd1 : 32'd0);
      step();
    end
    rd_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("src_dout",  dout, 32'hA000_0000 + 32'(k));
      chk("src_empty", 32'(empty), 32'd0);
      step();
    end
    rd_en = 1'b0;
    chk("src_empty_end", 32'(empty), 32'd1);
    chk("src_unf",       32'(underflow), 32'd0);

    // Three words resident, then simultaneous write+read for 20 cycles.
    src_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      src_data = 32'hB000_0000 + 32'(k);
      step();
    end
    rd_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      src_data = 32'hB000_0003 + 32'(k);
      chk("rw_dout", dout, 32'hB000_0000 + 32'(k));
      chk("rw_wc",   32'(word_count), 32'd3);
      step();
    end
    src_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rw_tail", dout, 32'hB000_0014 + 32'(k));
      step();
    end
    rd_en = 1'b0;
    chk("rw_empty", 32'(empty), 32'd1);
    chk("rw_unf",   32'(underflow), 32'd0);

    // Write and read on an empty buffer in the same cycle.
    src_valid = 1'b1;
    src_data  = 32'h1234_5678;
    rd_en     = 1'b1;
    step();
    src_valid = 1'b0;
    rd_en     = 1'b0;
    chk("wr_empty_unf",   32'(underflow), 32'd1);
    chk("wr_empty_wc",    32'(word_count), 32'd1);
    chk("wr_empty_dout",  dout, 32'h1234_5678);
    chk("wr_empty_empty", 32'(empty), 32'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("pop_one_empty", 32'(empty), 32'd1);

    // Pattern restarts at 0 on re-enable; fill exactly to full.
    pattern_en = 1'b1;
    repeat (512) step();
    pattern_en = 1'b0;
    chk("refill_wc",   32'(word_count), 32'd512);
    chk("refill_dout", dout, 32'h0);
    chk("refill_drop", 32'(drop_count), 32'd6);

    // Full: simultaneous pop and write, the write is dropped.
    src_valid = 1'b1;
    src_data  = 32'hDEAD_BEEF;
    rd_en     = 1'b1;
    step();
    src_valid = 1'b0;
    chk("full_rw_drop", 32'(drop_count), 32'd7);
    chk("full_rw_wc",   32'(word_count), 32'd511);
    chk("full_rw_dout", dout, 32'd1);

    // Drain to 100 words, then clear with a write and read pending.
    repeat (411) step();
    rd_en = 1'b0;
    chk("pre_clr_wc",   32'(word_count), 32'd100);
    chk("pre_clr_dout", dout, 32'd412);
    chk("pre_clr_ovf",  32'(overflow), 32'd1);
    chk("pre_clr_unf",  32'(underflow), 32'd1);
    clear     = 1'b1;
    src_valid = 1'b1;
    src_data  = 32'h5555_AAAA;
    rd_en     = 1'b1;
    step();
    clear     = 1'b0;
    src_valid = 1'b0;
    rd_en     = 1'b0;
    chk_reset_state("clear");

    // Asynchronous reset in the middle of a write burst.
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("pre_rst_unf", 32'(underflow), 32'd1);
    src_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      src_data = 32'hC000_0000 + 32'(k);
      step();
    end
    chk("pre_rst_wc",   32'(word_count), 32'd5);
    chk("pre_rst_dout", dout, 32'hC000_0000);
    #2;
    reset_ = 1'b0;
    #1;
    chk_reset_state("async_rst");
    src_valid = 1'b0;
    step();
    reset_ = 1'b1;
    step();
    chk("post_rst_wc", 32'(word_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
